key_slot_manager: RTL
=====================

Name: key_slot_manager

Overview:
- Manages a 4-slot SM4 round-key buffer shared by the encrypt and decrypt request channels.
- Arbitrates the two requesters round-robin, looks up the requested key tag, and handles misses:
  - picks a victim slot (invalid first, otherwise LRU);
  - sequences the key-expansion engine to fill that slot.
- Grants the slot index to the winning requester and reports each use to the lru_recorder instance in the parent.

Parameters:
- TAG_W, 32, width of the key identifier tag compared per slot.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- req_v_i  in  2  request valid; bit0 = encrypt channel, bit1 = decrypt channel
- req_tag0_i  in  TAG_W  key tag from requester 0
- req_tag1_i  in  TAG_W  key tag from requester 1
- req_ready_o  out  2  one-hot accept pulse to the arbitration winner
- flush_i  in  1  invalidate all slots
- grant_v_o  out  1  grant valid
- grant_id_o  out  1  requester being granted
- grant_slot_o  out  2  slot holding the requested round keys
- grant_hit_o  out  1  1 = tag already resident, 0 = freshly expanded
- grant_ready_i  in  1  grant accepted
- exp_v_o  out  1  key-expansion start request
- exp_slot_o  out  2  slot to fill
- exp_tag_o  out  TAG_W  tag being expanded
- exp_ready_i  in  1  expansion engine accepts start
- exp_done_i  in  1  expansion finished (1-cycle pulse)
- lru_v_o  out  1  access report strobe; connect to lru_recorder v1_i
- lru_access_o  out  2  slot accessed; connect to lru_recorder access1_i
- lru_replace_i  in  2  current LRU victim; from lru_recorder replace_which_o

Behaviour:
- Reset (reset_n_i=0 at a clock edge) gives:
  - state IDLE, all slot valid bits 0, round-robin pointer 0;
  - req_ready_o, grant_v_o, exp_v_o and lru_v_o all 0; other outputs 0.
- Reset applied mid-operation aborts the transaction; nothing is granted.
- The parent drives lru_recorder reset with ~reset_n_i.
- States: IDLE, LOOKUP, EXP_REQ, EXP_WAIT, GRANT.
- IDLE:
  - If any req_v_i bit is set, select a winner. When both are set, the winner is the pointer's channel.
  - Pulse that winner's req_ready_o combinationally in the same cycle.
  - Latch its tag and id, then go to LOOKUP.
- LOOKUP (exactly 1 cycle): compare the latched tag against all valid slots.
  - Hit: record the slot, set hit=1, go to GRANT.
  - Miss: victim = lowest-index invalid slot, or lru_replace_i if all four are valid. Clear the victim's valid bit, set hit=0, go to EXP_REQ.
- EXP_REQ: hold exp_v_o=1 with exp_slot_o and exp_tag_o stable until exp_ready_i=1, then go to EXP_WAIT.
- EXP_WAIT: on exp_done_i, write the tag into the victim slot, set its valid bit, go to GRANT.
  - exp_done_i in any other state is ignored.
- GRANT:
  - Hold grant_v_o=1 with grant_id_o, grant_slot_o and grant_hit_o stable until grant_ready_i=1.
  - In the handshake cycle, also pulse lru_v_o=1 with lru_access_o=slot, toggle the pointer to the other channel, and go to IDLE.
- Latency:
  - hit: grant_v_o rises 2 cycles after the accept cycle.
  - miss: exp_v_o rises 2 cycles after accept; grant_v_o rises 1 cycle after exp_done_i.
- Flush:
  - flush_i clears all valid bits on the next edge, in any state.
  - If flush_i and exp_done_i coincide, the fill's valid-set wins for the filled slot.
  - A grant that is pending keeps its slot index.
- Duplicate tags never coexist, because misses only occur when no valid slot matches.
- Requests are not accepted outside IDLE; req_ready_o=0 there.

Decomposition:
- Package sm4_key_pkg holds:
  - NUM_SLOTS=4;
  - typedef slot_idx_t (logic [1:0]);
  - enum ksm_state_e {IDLE, LOOKUP, EXP_REQ, EXP_WAIT, GRANT}.
- Sub-module key_tag_array owns:
  - tag and valid registers, with write and flush ports;
  - parallel compare producing hit and hit_slot;
  - first_invalid index and all_valid flag.
- The FSM, round-robin pointer and handshakes stay in key_slot_manager.

Test Plan:
- Reset, then req0 tag 0xA5 with exp_ready_i=1 and exp_done_i pulsed 3 cycles after exp_v_o -> exp_slot_o=0, then grant slot 0 with hit=0, lru_access_o=0.
- Repeat req0 tag 0xA5 -> no exp_v_o; grant_v_o 2 cycles after accept with slot 0, hit=1.
- Fill tags 1,2,3,4 into slots 0-3; access slots 1,2,3, then request tag 5 -> victim = lru_replace_i = 0; exp_slot_o=0; tag 1 then misses.
- Both req_v_i held continuously after reset -> accepts alternate ch0, ch1, ch0, ch1; grant_id_o matches each.
- Assert flush_i while in GRANT for slot 2 -> grant still shows slot 2; the next request for the same tag misses, and the victim is slot 0 (lowest invalid).
- Drop reset_n_i during EXP_WAIT -> next cycle all outputs 0 and state IDLE; a later exp_done_i is ignored and no grant is issued.

Source files
------------

// File: rtl/sm4_key_pkg.sv
// rtl/sm4_key_pkg.sv - shared types for the SM4 round-key slot manager
package sm4_key_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        EXP_REQ,
        EXP_WAIT,
        GRANT
    } ksm_state_e;

endpackage

// File: rtl/key_tag_array.sv
// rtl/key_tag_array.sv - per-slot key tags and valid bits with parallel tag compare
module key_tag_array
    import sm4_key_pkg::*;
#(
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             flush_i,
    input  logic             fill_en_i,
    input  slot_idx_t        fill_slot_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic             inv_en_i,
    input  slot_idx_t        inv_slot_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output slot_idx_t        hit_slot_o,
    output slot_idx_t        first_invalid_o,
    output logic             all_valid_o
);

    logic [TAG_W-1:0]     tag_q [NUM_SLOTS];
    logic [TAG_W-1:0]     tag_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_q;
    logic [NUM_SLOTS-1:0] valid_d;

    // Next slot contents; a fill is applied last so it survives a coincident flush
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (flush_i) begin
            valid_d = '0;
        end
        if (inv_en_i) begin
            valid_d[inv_slot_i] = 1'b0;
        end
        if (fill_en_i) begin
            valid_d[fill_slot_i] = 1'b1;
            tag_d[fill_slot_i]   = fill_tag_i;
        end
    end

    // Slot storage
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Tag match and lowest-index free slot; scanning downward leaves the lowest index
    always_comb begin
        hit_o           = 1'b0;
        hit_slot_o      = '0;
        first_invalid_o = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
                hit_o      = 1'b1;
                hit_slot_o = slot_idx_t'(i);
            end
            if (!valid_q[i]) begin
                first_invalid_o = slot_idx_t'(i);
            end
        end
    end

    assign all_valid_o = &valid_q;

endmodule

// File: rtl/key_slot_manager.sv
// rtl/key_slot_manager.sv - arbitrates key requests, looks up slots, sequences key expansion on miss
module key_slot_manager
    import sm4_key_pkg::*;
#(
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [1:0]       req_v_i,
    input  logic [TAG_W-1:0] req_tag0_i,
    input  logic [TAG_W-1:0] req_tag1_i,
    output logic [1:0]       req_ready_o,
    input  logic             flush_i,
    output logic             grant_v_o,
    output logic             grant_id_o,
    output logic [1:0]       grant_slot_o,
    output logic             grant_hit_o,
    input  logic             grant_ready_i,
    output logic             exp_v_o,
    output logic [1:0]       exp_slot_o,
    output logic [TAG_W-1:0] exp_tag_o,
    input  logic             exp_ready_i,
    input  logic             exp_done_i,
    output logic             lru_v_o,
    output logic [1:0]       lru_access_o,
    input  logic [1:0]       lru_replace_i
);

    ksm_state_e       state_q, state_d;
    logic             rr_q, rr_d;
    logic             id_q, id_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    slot_idx_t        slot_q, slot_d;
    logic             hit_q, hit_d;

    logic             win_id;
    logic             accept;
    logic             fill_en;
    logic             inv_en;
    logic             arr_hit;
    slot_idx_t        arr_hit_slot;
    slot_idx_t        arr_first_invalid;
    logic             arr_all_valid;

    key_tag_array #(.TAG_W(TAG_W)) u_tags (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .flush_i         (flush_i),
        .fill_en_i       (fill_en),
        .fill_slot_i     (slot_q),
        .fill_tag_i      (tag_q),
        .inv_en_i        (inv_en),
        .inv_slot_i      (slot_d),
        .lookup_tag_i    (tag_q),
        .hit_o           (arr_hit),
        .hit_slot_o      (arr_hit_slot),
        .first_invalid_o (arr_first_invalid),
        .all_valid_o     (arr_all_valid)
    );

    // Round-robin winner and same-cycle accept pulse; the pointer only matters when both ask
    always_comb begin
        win_id      = (req_v_i == 2'b11) ? rr_q : req_v_i[1];
        accept      = reset_n_i && (state_q == IDLE) && (req_v_i != 2'b00);
        req_ready_o = 2'b00;
        if (accept) begin
            req_ready_o = win_id ? 2'b10 : 2'b01;
        end
    end

    // Transaction sequencing: accept, lookup, optional expansion, grant
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        tag_d   = tag_q;
        slot_d  = slot_q;
        hit_d   = hit_q;
        fill_en = 1'b0;
        inv_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = win_id;
                    tag_d   = win_id ? req_tag1_i : req_tag0_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (arr_hit) begin
                    slot_d  = arr_hit_slot;
                    hit_d   = 1'b1;
                    state_d = GRANT;
                end else begin
                    slot_d  = arr_all_valid ? lru_replace_i : arr_first_invalid;
                    inv_en  = 1'b1;
                    hit_d   = 1'b0;
                    state_d = EXP_REQ;
                end
            end
            EXP_REQ: begin
                if (exp_ready_i) begin
                    state_d = EXP_WAIT;
                end
            end
            EXP_WAIT: begin
                if (exp_done_i) begin
                    fill_en = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (grant_ready_i) begin
                    rr_d    = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and transaction registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            tag_q   <= '0;
            slot_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            tag_q   <= tag_d;
            slot_q  <= slot_d;
            hit_q   <= hit_d;
        end
    end

    // Outputs decoded from state registers; payloads are zero when their strobe is low
    always_comb begin
        exp_v_o      = (state_q == EXP_REQ);
        grant_v_o    = (state_q == GRANT);
        lru_v_o      = grant_v_o && grant_ready_i;
        exp_slot_o   = exp_v_o ? slot_q : 2'b00;
        exp_tag_o    = exp_v_o ? tag_q : '0;
        grant_id_o   = grant_v_o ? id_q : 1'b0;
        grant_slot_o = grant_v_o ? slot_q : 2'b00;
        grant_hit_o  = grant_v_o ? hit_q : 1'b0;
        lru_access_o = lru_v_o ? slot_q : 2'b00;
    end

endmodule
